// File: rtl/axis_ema_arbiter_pkg.sv
// Shared types for the EMA input arbiter: the beat carried through the
// register slice and the two-state packet arbitration FSM encoding.
package ema_pkg;

  localparam int EMA_DATA_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic [EMA_DATA_W-1:0]   tdata;
    logic [EMA_DATA_W/8-1:0] tkeep;
    logic                    tlast;
    logic                    tid;
  } axis_beat_t;

endpackage

// File: rtl/axis_ema_arbiter_if.sv
// AXI-Stream bundle: master drives payload/valid, slave drives ready.
// The slave view omits tid because upstream requesters carry no source tag.
interface axis_ema_arbiter_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0]   tdata;
  logic [DATA_W/8-1:0] tkeep;
  logic                tlast;
  logic                tid;
  logic                tvalid;
  logic                tready;

  modport master (output tdata, tkeep, tlast, tid, tvalid, input tready);
  modport slave  (input tdata, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/axis_ema_arbiter_reg_slice.sv
// Two-entry skid buffer on axis_beat_t: full throughput, and the input ready
// comes straight from a flop so no combinational path crosses the slice.
module axis_reg_slice
  import ema_pkg::*;
(
  input  logic       ACLK,
  input  logic       ARESETN,
  input  axis_beat_t s_beat,
  input  logic       s_valid,
  output logic       s_ready,
  output axis_beat_t m_beat,
  output logic       m_valid,
  input  logic       m_ready
);

  axis_beat_t main_q, main_d;
  axis_beat_t skid_q, skid_d;
  logic       main_valid_q, main_valid_d;
  logic       skid_valid_q, skid_valid_d;
  logic       in_fire;

  always_comb begin
    in_fire      = s_valid & ~skid_valid_q;
    main_d       = main_q;
    main_valid_d = main_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (!main_valid_q || m_ready) begin
      // Output register is free: refill from the skid entry first to keep order.
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = in_fire;
        if (in_fire) begin
          main_d = s_beat;
        end
      end
    end else if (in_fire) begin
      skid_d       = s_beat;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign s_ready = ~skid_valid_q;
  assign m_beat  = main_q;
  assign m_valid = main_valid_q;

endmodule

// File: rtl/axis_ema_arbiter.sv
// Packet-granular round-robin arbiter sharing the EMA slave port between two
// AXI-Stream requesters; output goes through a skid slice tagged with TID.
module axis_ema_arbiter
  import ema_pkg::*;
#(
  parameter int DATA_W = EMA_DATA_W,
  parameter int CNT_W  = 16
) (
  input  logic                ACLK,
  input  logic                ARESETN,
  axis_ema_arbiter_if.slave   s0_axis,
  axis_ema_arbiter_if.slave   s1_axis,
  axis_ema_arbiter_if.master  m_axis,
  output logic [CNT_W-1:0]    PKT_CNT0,
  output logic [CNT_W-1:0]    PKT_CNT1
);

  arb_state_t              state_q, state_d;
  logic                    sel_q, sel_d;
  logic                    rr_ptr_q, rr_ptr_d;
  logic [1:0][CNT_W-1:0]   cnt_q, cnt_d;

  logic                    sel_valid;
  logic [DATA_W-1:0]       sel_data;
  logic [DATA_W/8-1:0]     sel_keep;
  axis_beat_t              sel_beat;
  logic                    slice_in_valid;
  logic                    slice_in_ready;
  logic                    accept;
  axis_beat_t              out_beat;
  logic                    out_valid;

  always_comb begin
    sel_valid      = sel_q ? s1_axis.tvalid : s0_axis.tvalid;
    sel_data       = sel_q ? s1_axis.tdata  : s0_axis.tdata;
    sel_keep       = sel_q ? s1_axis.tkeep  : s0_axis.tkeep;
    sel_beat.tdata = sel_data;
    sel_beat.tkeep = sel_keep;
    sel_beat.tlast = sel_q ? s1_axis.tlast : s0_axis.tlast;
    sel_beat.tid   = sel_q;
    slice_in_valid = (state_q == BUSY) & sel_valid;
    accept         = slice_in_valid & slice_in_ready;

    state_d  = state_q;
    sel_d    = sel_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        // Grant is registered here, which forces the one-cycle bubble between packets.
        if (s0_axis.tvalid || s1_axis.tvalid) begin
          state_d = BUSY;
          sel_d   = (s0_axis.tvalid && s1_axis.tvalid) ? rr_ptr_q : s1_axis.tvalid;
        end
      end
      BUSY: begin
        if (accept && sel_beat.tlast) begin
          state_d       = IDLE;
          rr_ptr_d      = ~sel_q;
          cnt_d[sel_q]  = cnt_q[sel_q] + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q  <= IDLE;
      sel_q    <= 1'b0;
      rr_ptr_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign s0_axis.tready = (state_q == BUSY) & ~sel_q & slice_in_ready;
  assign s1_axis.tready = (state_q == BUSY) &  sel_q & slice_in_ready;

  axis_reg_slice u_slice (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .s_beat  (sel_beat),
    .s_valid (slice_in_valid),
    .s_ready (slice_in_ready),
    .m_beat  (out_beat),
    .m_valid (out_valid),
    .m_ready (m_axis.tready)
  );

  assign m_axis.tdata  = out_beat.tdata;
  assign m_axis.tkeep  = out_beat.tkeep;
  assign m_axis.tlast  = out_beat.tlast;
  assign m_axis.tid    = out_beat.tid;
  assign m_axis.tvalid = out_valid;

  assign PKT_CNT0 = cnt_q[0];
  assign PKT_CNT1 = cnt_q[1];

endmodule

// File: tb/tb_axis_ema_arbiter.sv
// Randomized bench for axis_ema_arbiter: per-source packet scoreboards,
// round-robin/bubble rules, output hold rules and modular packet counters.
module tb_axis_ema_arbiter;
  import ema_pkg::*;

  localparam int DATA_W   = 32;
  localparam int CNT_W    = 2;
  localparam int CNT_MASK = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axis_ema_arbiter_if #(.DATA_W(DATA_W)) s0_if ();
  axis_ema_arbiter_if #(.DATA_W(DATA_W)) s1_if ();
  axis_ema_arbiter_if #(.DATA_W(DATA_W)) m_if ();
  logic [CNT_W-1:0] pkt_cnt0, pkt_cnt1;

  axis_ema_arbiter #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .ACLK     (clk),
    .ARESETN  (rst_n),
    .s0_axis  (s0_if),
    .s1_axis  (s1_if),
    .m_axis   (m_if),
    .PKT_CNT0 (pkt_cnt0),
    .PKT_CNT1 (pkt_cnt1)
  );

  beat_t send0_q[$], send1_q[$], exp0_q[$], exp1_q[$];
  int    n_vec = 0, n_err = 0;
  int    sent_cnt[2], stop_at[2], model_cnt[2];
  int    valid_pct = 100, gap_cycles = 0;
  bit    bp_mode = 0, in_pkt = 0, cur_tid = 0, have_last = 1, last_tid = 1;
  bit    fair_chk = 1, bubble_chk = 1, bubble_armed = 0, prev_stall = 0;
  logic [31:0] prev_data;
  logic [3:0]  prev_keep;
  logic        prev_last, prev_tid;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic int q_size(input int s);
    return (s != 0) ? send1_q.size() : send0_q.size();
  endfunction

  function automatic beat_t q_front(input int s);
    return (s != 0) ? send1_q[0] : send0_q[0];
  endfunction

  task automatic q_pop(input int s);
    if (s != 0) begin if (send1_q.size() > 0) void'(send1_q.pop_front()); end
    else begin if (send0_q.size() > 0) void'(send0_q.pop_front()); end
  endtask

  task automatic push_pkt(input int s, input int len, input logic [31:0] base, input bit rnd);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = rnd ? $urandom : base + 32'(i);
      b.keep = 4'($urandom);
      b.last = (i == len - 1);
      if (s != 0) begin send1_q.push_back(b); exp1_q.push_back(b); end
      else begin send0_q.push_back(b); exp0_q.push_back(b); end
    end
  endtask

  task automatic set_src(input int s, input bit v, input beat_t b);
    if (s != 0) begin
      s1_if.tvalid = v; s1_if.tdata = b.data; s1_if.tkeep = b.keep; s1_if.tlast = b.last;
    end else begin
      s0_if.tvalid = v; s0_if.tdata = b.data; s0_if.tkeep = b.keep; s0_if.tlast = b.last;
    end
  endtask

  task automatic monitor_beat();
    beat_t e;
    int    sz;
    if (in_pkt) check_eq("tid_hold", m_if.tid, cur_tid);
    else begin
      if (fair_chk && have_last) check_eq("rr_grant", m_if.tid, !last_tid);
      if (bubble_chk && bubble_armed) check_eq("bubble", gap_cycles, 1);
    end
    sz = (m_if.tid == 1'b1) ? exp1_q.size() : exp0_q.size();
    check_eq("sb_nonempty", sz > 0, 1);
    if (sz > 0) begin
      e = (m_if.tid == 1'b1) ? exp1_q.pop_front() : exp0_q.pop_front();
      check_eq("m_tdata", m_if.tdata, e.data);
      check_eq("m_tkeep", m_if.tkeep, e.keep);
      check_eq("m_tlast", m_if.tlast, e.last);
    end
    in_pkt  = !m_if.tlast;
    cur_tid = m_if.tid;
    if (m_if.tlast) begin
      have_last = 1; last_tid = m_if.tid; bubble_armed = 1; gap_cycles = 0;
    end
  endtask

  // Engine: samples at negedge, drives sources and sink ready just after posedge.
  initial begin : engine
    bit    fire[2];
    beat_t z;
    bit    cur_v;
    z = '0;
    stop_at[0] = -1; stop_at[1] = -1;
    set_src(0, 0, z); set_src(1, 0, z);
    s0_if.tid = 1'b0; s1_if.tid = 1'b0;
    m_if.tready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check_eq("pkt_cnt0", pkt_cnt0, model_cnt[0] & CNT_MASK);
        check_eq("pkt_cnt1", pkt_cnt1, model_cnt[1] & CNT_MASK);
        if (prev_stall) begin
          check_eq("hold_valid", m_if.tvalid, 1);
          check_eq("hold_data", m_if.tdata, prev_data);
          check_eq("hold_keep", m_if.tkeep, prev_keep);
          check_eq("hold_last", m_if.tlast, prev_last);
          check_eq("hold_tid", m_if.tid, prev_tid);
        end
        if (m_if.tvalid && m_if.tready) monitor_beat();
        else if (!m_if.tvalid) gap_cycles++;
        prev_stall = m_if.tvalid & ~m_if.tready;
        prev_data = m_if.tdata; prev_keep = m_if.tkeep;
        prev_last = m_if.tlast; prev_tid = m_if.tid;
      end else begin
        prev_stall = 0;
      end
      fire[0] = s0_if.tvalid & s0_if.tready;
      fire[1] = s1_if.tvalid & s1_if.tready;
      for (int s = 0; s < 2; s++) begin
        if (fire[s] && q_size(s) > 0) begin
          sent_cnt[s]++;
          if (q_front(s).last) model_cnt[s]++;
        end
      end
      @(posedge clk);
      #1;
      if (!rst_n) begin model_cnt[0] = 0; model_cnt[1] = 0; end
      for (int s = 0; s < 2; s++) begin
        if (fire[s]) q_pop(s);
        cur_v = (s != 0) ? s1_if.tvalid : s0_if.tvalid;
        if (q_size(s) == 0) set_src(s, 0, z);
        else if (fire[s] || !cur_v)
          set_src(s, (sent_cnt[s] != stop_at[s]) && ($urandom_range(0, 99) < valid_pct), q_front(s));
      end
      m_if.tready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic drain();
    int n = 0;
    while ((send0_q.size() + send1_q.size() + exp0_q.size() + exp1_q.size()) != 0 && n < 3000) begin
      step(); n++;
    end
    check_eq("drain_done", n < 3000, 1);
    step(3);
  endtask

  task automatic wait_sent(input int s, input int target);
    int n = 0;
    while (sent_cnt[s] != target && n < 200) begin step(); n++; end
    check_eq("stall_reached", sent_cnt[s], target);
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_m_tvalid", m_if.tvalid, 0);
    check_eq("rst_s0_tready", s0_if.tready, 0);
    check_eq("rst_s1_tready", s1_if.tready, 0);
    check_eq("rst_m_tid", m_if.tid, 0);
    check_eq("rst_cnt0", pkt_cnt0, 0);
    check_eq("rst_cnt1", pkt_cnt1, 0);
  endtask

  initial begin : sequencer
    // Reset with both sources already offering their contention packets.
    push_pkt(0, 4, 32'h10, 0);
    push_pkt(1, 3, 32'h20, 0);
    repeat (3) begin step(); check_reset_outputs(); end
    rst_n = 1'b1;
    drain();
    check_eq("contention_cnt0", pkt_cnt0, 1);
    check_eq("contention_cnt1", pkt_cnt1, 1);

    // Fairness: both sources keep 2-beat packets queued.
    bubble_armed = 0;
    for (int i = 0; i < 5; i++) begin
      push_pkt(0, 2, 32'h100 + 32'(i * 16), 0);
      push_pkt(1, 2, 32'h200 + 32'(i * 16), 0);
    end
    drain();
    check_eq("fair_cnt0", pkt_cnt0, 6 & CNT_MASK);
    check_eq("fair_cnt1", pkt_cnt1, 6 & CNT_MASK);

    // Backpressure on one long packet, then fully random traffic.
    fair_chk = 0; bubble_chk = 0; bp_mode = 1;
    push_pkt(1, 8, 32'hA0, 0);
    drain();
    valid_pct = 60;
    for (int i = 0; i < 30; i++) begin
      push_pkt($urandom_range(0, 1), $urandom_range(1, 6), 32'h0, 1);
      if ($urandom_range(0, 2) == 0) step($urandom_range(1, 4));
    end
    drain();

    // Granted source stalls mid-packet while the other waits.
    bp_mode = 0; valid_pct = 100;
    stop_at[0] = sent_cnt[0] + 2;
    push_pkt(0, 4, 32'h30, 0);
    step(2);
    push_pkt(1, 2, 32'h40, 0);
    wait_sent(0, stop_at[0]);
    repeat (6) begin step(); check_eq("s1_ready_stall", s1_if.tready, 0); end
    stop_at[0] = -1;
    drain();

    // Reset in the middle of a packet drops everything in flight.
    stop_at[0] = sent_cnt[0] + 2;
    push_pkt(0, 4, 32'h50, 0);
    wait_sent(0, stop_at[0]);
    step();
    rst_n = 1'b0;
    send0_q.delete(); send1_q.delete(); exp0_q.delete(); exp1_q.delete();
    in_pkt = 0; have_last = 1; last_tid = 1; bubble_armed = 0;
    step();
    check_reset_outputs();
    rst_n = 1'b1;
    stop_at[0] = -1;
    step();
    check_eq("post_rst_s0_tready", s0_if.tready, 0);

    // Counter wrap: five single-beat packets from S1.
    for (int i = 0; i < 5; i++) push_pkt(1, 1, 32'hC0 + 32'(i), 0);
    drain();
    check_eq("wrap_cnt1", pkt_cnt1, 5 & CNT_MASK);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
